// File: rtl/io_dev_arb_if.sv
// Bus bundle for io_dev_arb: keyboard source, screen sink, CPU register port and irq.
// The master side is the system around the arbiter; the slave side is the arbiter itself.
interface io_dev_arb_if;
    logic       kb_valid;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       scr_valid;
    logic [7:0] scr_data;
    logic       scr_ready;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       irq;

    modport master (
        output kb_valid, kb_data, scr_ready, cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
        input  kb_ready, scr_valid, scr_data, cpu_rdata, irq
    );

    modport slave (
        input  kb_valid, kb_data, scr_ready, cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
        output kb_ready, scr_valid, scr_data, cpu_rdata, irq
    );
endinterface

// File: rtl/io_dev_arb.sv
// io_dev_arb: round-robin arbiter moving bytes keyboard->CPU and CPU->screen via CSRs.
// Optional macro IO_DEV_ARB_TIMEOUT_EN adds a 255-cycle screen transfer timeout.
module io_dev_arb (
    input  logic        clk,
    input  logic        rst_n,
    io_dev_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, KB_XFER, SCR_XFER} state_t;

    state_t     state_q, state_d;
    logic       last_scr_q, last_scr_d;

    logic       kb_ena_q, kb_ena_d;
    logic       kb_ie_q, kb_ie_d;
    logic       kb_of_q, kb_of_d;
    logic       kb_dba_q, kb_dba_d;
    logic [7:0] kb_dreg_q, kb_dreg_d;

    logic       scr_ena_q, scr_ena_d;
    logic       scr_ie_q, scr_ie_d;
    logic       scr_of_q, scr_of_d;
    logic       scr_dba_q, scr_dba_d;
    logic [7:0] scr_dreg_q, scr_dreg_d;

    logic       kb_ready_q, kb_ready_d;
    logic       scr_valid_q, scr_valid_d;
    logic       irq_q, irq_d;

    logic       kb_csr_wr, kb_data_rd, scr_csr_wr, scr_data_wr;
    logic       kb_pend, scr_pend;
    logic [7:0] rdata_c;
    logic       unused_wdata;

`ifdef IO_DEV_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_hit;

    // 255th consecutive SCR_XFER cycle without scr_ready
    assign tmo_hit = (state_q == SCR_XFER) && !bus.scr_ready && (tmo_cnt_q == 8'd254);
`endif

    assign kb_csr_wr   = bus.cpu_wr && (bus.cpu_addr == 2'd0);
    assign kb_data_rd  = bus.cpu_rd && (bus.cpu_addr == 2'd1);
    assign scr_csr_wr  = bus.cpu_wr && (bus.cpu_addr == 2'd2);
    assign scr_data_wr = bus.cpu_wr && (bus.cpu_addr == 2'd3);

    assign kb_pend  = kb_ena_q && bus.kb_valid;
    assign scr_pend = scr_ena_q && !scr_dba_q;

    assign unused_wdata = &{1'b0, bus.cpu_wdata[7:5], bus.cpu_wdata[2:1]};

    always_comb begin
        state_d     = state_q;
        last_scr_d  = last_scr_q;
        kb_ena_d    = kb_ena_q;
        kb_ie_d     = kb_ie_q;
        kb_of_d     = kb_of_q;
        kb_dba_d    = kb_dba_q;
        kb_dreg_d   = kb_dreg_q;
        scr_ena_d   = scr_ena_q;
        scr_ie_d    = scr_ie_q;
        scr_of_d    = scr_of_q;
        scr_dba_d   = scr_dba_q;
        scr_dreg_d  = scr_dreg_q;

        if (kb_csr_wr) begin
            kb_ena_d = bus.cpu_wdata[4];
            kb_ie_d  = bus.cpu_wdata[0];
            if (bus.cpu_wdata[3]) kb_of_d = 1'b0;
        end
        if (kb_data_rd) kb_dba_d = 1'b0;

        if (scr_csr_wr) begin
            scr_ena_d = bus.cpu_wdata[4];
            scr_ie_d  = bus.cpu_wdata[0];
            if (bus.cpu_wdata[3]) scr_of_d = 1'b0;
        end

        // A write while the byte is on the wire is dropped so scr_data stays stable
        if (scr_data_wr) begin
            if (state_q == SCR_XFER) begin
                scr_of_d = 1'b1;
            end else begin
                scr_dreg_d = bus.cpu_wdata;
                scr_dba_d  = 1'b0;
                if (!scr_dba_q) scr_of_d = 1'b1;
            end
        end

        // Transfer side effects come last so a hardware event beats a CPU clear
        case (state_q)
            IDLE: begin
                if (kb_pend && (!scr_pend || last_scr_q)) begin
                    state_d    = KB_XFER;
                    last_scr_d = 1'b0;
                end else if (scr_pend) begin
                    state_d    = SCR_XFER;
                    last_scr_d = 1'b1;
                end
            end
            KB_XFER: begin
                kb_dreg_d = bus.kb_data;
                kb_dba_d  = 1'b1;
                if (kb_dba_q && !kb_data_rd) kb_of_d = 1'b1;
                state_d   = IDLE;
            end
            SCR_XFER: begin
                if (bus.scr_ready) begin
                    scr_dba_d = 1'b1;
                    state_d   = IDLE;
                end
`ifdef IO_DEV_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    scr_of_d  = 1'b1;
                    scr_dba_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        kb_ready_d  = (state_d == KB_XFER);
        scr_valid_d = (state_d == SCR_XFER);
        irq_d       = (kb_ie_q && kb_dba_q) || (scr_ie_q && scr_dba_q);

`ifdef IO_DEV_ARB_TIMEOUT_EN
        tmo_cnt_d = ((state_q == SCR_XFER) && (state_d == SCR_XFER)) ? tmo_cnt_q + 8'd1 : 8'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_scr_q  <= 1'b1;
            kb_ena_q    <= 1'b0;
            kb_ie_q     <= 1'b0;
            kb_of_q     <= 1'b0;
            kb_dba_q    <= 1'b0;
            kb_dreg_q   <= 8'h00;
            scr_ena_q   <= 1'b0;
            scr_ie_q    <= 1'b0;
            scr_of_q    <= 1'b0;
            scr_dba_q   <= 1'b1;
            scr_dreg_q  <= 8'h00;
            kb_ready_q  <= 1'b0;
            scr_valid_q <= 1'b0;
            irq_q       <= 1'b0;
`ifdef IO_DEV_ARB_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            last_scr_q  <= last_scr_d;
            kb_ena_q    <= kb_ena_d;
            kb_ie_q     <= kb_ie_d;
            kb_of_q     <= kb_of_d;
            kb_dba_q    <= kb_dba_d;
            kb_dreg_q   <= kb_dreg_d;
            scr_ena_q   <= scr_ena_d;
            scr_ie_q    <= scr_ie_d;
            scr_of_q    <= scr_of_d;
            scr_dba_q   <= scr_dba_d;
            scr_dreg_q  <= scr_dreg_d;
            kb_ready_q  <= kb_ready_d;
            scr_valid_q <= scr_valid_d;
            irq_q       <= irq_d;
`ifdef IO_DEV_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        rdata_c = 8'h00;
        case (bus.cpu_addr)
            2'd0: rdata_c = {3'b000, kb_ena_q, kb_of_q, kb_dba_q, 1'b0, kb_ie_q};
            2'd1: rdata_c = kb_dreg_q;
            2'd2: rdata_c = {3'b000, scr_ena_q, scr_of_q, scr_dba_q, 1'b1, scr_ie_q};
            2'd3: rdata_c = scr_dreg_q;
            default: rdata_c = 8'h00;
        endcase
    end

    assign bus.cpu_rdata = rdata_c;
    assign bus.kb_ready  = kb_ready_q;
    assign bus.scr_valid = scr_valid_q;
    assign bus.scr_data  = scr_dreg_q;
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_io_dev_arb.sv
// Testbench for io_dev_arb: randomized traffic against a register-level model with scoreboard queues.
// Define IO_DEV_ARB_TIMEOUT_EN for both bench and RTL to exercise the screen timeout.
module tb_io_dev_arb;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    io_dev_arb_if bus ();

    io_dev_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_q[$];
    logic [7:0] scr_q[$];
    logic [7:0] grants[$];
    bit         rr_active = 1'b0;

    bit         m_kb_ena, m_kb_ie, m_kb_of, m_kb_dba;
    logic [7:0] m_kb_data;
    bit         m_scr_ena, m_scr_ie, m_scr_of, m_scr_dba, m_scr_busy;
    logic [7:0] m_scr_data;

    function automatic logic [7:0] csrVal(input bit ena, input bit of, input bit dba, input bit io, input bit ie);
        return {3'b000, ena, of, dba, io, ie};
    endfunction

    function automatic bit expIrq();
        return (m_kb_ie && m_kb_dba) || (m_scr_ie && m_scr_dba);
    endfunction

    task automatic modelReset();
        m_kb_ena = 0; m_kb_ie = 0; m_kb_of = 0; m_kb_dba = 0; m_kb_data = 8'h00;
        m_scr_ena = 0; m_scr_ie = 0; m_scr_of = 0; m_scr_dba = 1; m_scr_busy = 0; m_scr_data = 8'h00;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at posedge+1; drives one CPU cycle and returns at the following posedge+1
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] addr, input logic [7:0] wdata);
        bus.cpu_wr    = wr;
        bus.cpu_rd    = rd;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
    endtask

    task automatic cpuWrite(input logic [1:0] addr, input logic [7:0] d);
        case (addr)
            2'd0: begin m_kb_ena = d[4]; m_kb_ie = d[0]; if (d[3]) m_kb_of = 0; end
            2'd2: begin m_scr_ena = d[4]; m_scr_ie = d[0]; if (d[3]) m_scr_of = 0; end
            2'd3: begin
                if (m_scr_busy) m_scr_of = 1;
                else begin
                    if (!m_scr_dba) m_scr_of = 1;
                    m_scr_data = d;
                    m_scr_dba  = 0;
                end
            end
            default: ;
        endcase
        applyStimulus(1'b1, 1'b0, addr, d);
    endtask

    task automatic cpuRead(input logic [1:0] addr);
        logic [7:0] e;
        case (addr)
            2'd0: e = csrVal(m_kb_ena, m_kb_of, m_kb_dba, 1'b0, m_kb_ie);
            2'd1: e = m_kb_data;
            2'd2: e = csrVal(m_scr_ena, m_scr_of, m_scr_dba, 1'b1, m_scr_ie);
            default: e = m_scr_data;
        endcase
        rd_q.push_back(e);
        applyStimulus(1'b0, 1'b1, addr, 8'h00);
        if (addr == 2'd1) m_kb_dba = 0;
    endtask

    task automatic checkIrq();
        @(posedge clk); #1;
        checkOutput("irq", {7'b0, bus.irq}, {7'b0, expIrq()});
    endtask

    // Offer one keyboard byte; optionally read kb data in the capture cycle itself
    task automatic kbOffer(input logic [7:0] b, input bit read_in_xfer);
        int n;
        bus.kb_valid = 1'b1;
        bus.kb_data  = b;
        if (read_in_xfer) begin
            @(posedge clk); #1;
            checkOutput("kb_ready_in_xfer", {7'b0, bus.kb_ready}, 8'h01);
            cpuRead(2'd1);
            m_kb_dba  = 1;
            m_kb_data = b;
        end else begin
            n = 0;
            while (n < 8) begin
                @(negedge clk);
                n++;
                if (bus.kb_ready) break;
            end
            checkCount("kb_ready_latency", n, 2);
            @(posedge clk); #1;
            if (m_kb_dba) m_kb_of = 1;
            m_kb_dba  = 1;
            m_kb_data = b;
        end
        bus.kb_valid = 1'b0;
        @(negedge clk);
        checkOutput("kb_ready_single_pulse", {7'b0, bus.kb_ready}, 8'h00);
        @(posedge clk); #1;
    endtask

    // Expects a screen byte pending; holds scr_ready low for hold cycles, then completes
    task automatic scrXfer(input int hold, input bit drop_write, input bit clear_ena);
        int n;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (bus.scr_valid) break;
        end
        checkCount("scr_grant_latency", n, 2);
        m_scr_busy = 1;
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            if (i == 0 && drop_write) cpuWrite(2'd3, 8'($urandom));
            else if (i == 1 && clear_ena) cpuWrite(2'd2, csrVal(1'b0, 1'b0, 1'b0, 1'b0, m_scr_ie));
            else begin @(posedge clk); #1; end
            checkOutput("scr_valid_held", {7'b0, bus.scr_valid}, 8'h01);
            checkOutput("scr_data_stable", bus.scr_data, m_scr_data);
        end
        scr_q.push_back(m_scr_data);
        bus.scr_ready = 1'b1;
        @(posedge clk); #1;
        bus.scr_ready = 1'b0;
        m_scr_busy = 0;
        m_scr_dba  = 1;
        checkOutput("scr_valid_drop", {7'b0, bus.scr_valid}, 8'h00);
    endtask

    task automatic printSummary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Monitor: CPU read data and screen handshakes are compared against queued expectations
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.cpu_rd) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL cpu_rdata: got 0x%02h, expected nothing queued", bus.cpu_rdata);
                end else checkOutput("cpu_rdata", bus.cpu_rdata, rd_q.pop_front());
            end
            if (rst_n && bus.scr_valid && bus.scr_ready) begin
                if (scr_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL scr_data: got 0x%02h, expected no transfer", bus.scr_data);
                end else checkOutput("scr_data", bus.scr_data, scr_q.pop_front());
            end
        end
    end

    initial begin
        bit prev_sv = 1'b0;
        forever begin
            @(negedge clk);
            if (rr_active) begin
                if (bus.kb_ready) grants.push_back(8'h4B);
                if (bus.scr_valid && !prev_sv) grants.push_back(8'h53);
            end
            prev_sv = bus.scr_valid;
        end
    end

    initial begin
        #800000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached at %0t", $time);
        printSummary();
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        bit hs;
        int cyc;
        int n;

        rst_n = 1'b0;
        bus.kb_valid = 0; bus.kb_data = 0; bus.scr_ready = 0;
        bus.cpu_wr = 0; bus.cpu_rd = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        modelReset();
        #3;
        checkOutput("reset_kb_ready", {7'b0, bus.kb_ready}, 8'h00);
        checkOutput("reset_scr_valid", {7'b0, bus.scr_valid}, 8'h00);
        checkOutput("reset_scr_data", bus.scr_data, 8'h00);
        checkOutput("reset_irq", {7'b0, bus.irq}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpuRead(2'd0); cpuRead(2'd2); cpuRead(2'd1); cpuRead(2'd3);
        checkIrq();

        $display("[TB] keyboard channel");
        cpuWrite(2'd0, 8'h10);
        kbOffer(8'h41, 1'b0);
        cpuRead(2'd0); cpuRead(2'd1); cpuRead(2'd0);
        kbOffer(8'h41, 1'b0);
        kbOffer(8'h42, 1'b0);
        cpuRead(2'd0);
        cpuWrite(2'd0, 8'h18);
        cpuRead(2'd0); cpuRead(2'd1);
        kbOffer(8'h33, 1'b0);
        kbOffer(8'h77, 1'b1);
        cpuRead(2'd0); cpuRead(2'd1);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0)
                cpuWrite(2'd0, csrVal(1'b1, 1'($urandom), 1'b0, 1'b0, 1'($urandom)));
            kbOffer(8'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) cpuRead(2'd0);
            if ($urandom_range(0, 1) == 1) cpuRead(2'd1);
            checkIrq();
        end

        $display("[TB] screen channel");
        cpuWrite(2'd2, 8'h11);
        cpuWrite(2'd3, 8'h5A);
        scrXfer(3, 1'b0, 1'b0);
        cpuRead(2'd2);
        checkIrq();
        for (int i = 0; i < 8; i++) begin
            cpuWrite(2'd2, csrVal(1'b1, 1'($urandom), 1'b0, 1'b0, 1'($urandom)));
            cpuWrite(2'd3, 8'($urandom));
            scrXfer(2 + $urandom_range(0, 2), i == 2, i == 5);
            cpuRead(2'd2); cpuRead(2'd3);
            checkIrq();
        end
        cpuWrite(2'd2, 8'h01);
        cpuWrite(2'd3, 8'($urandom));
        cpuWrite(2'd3, 8'($urandom));
        cpuRead(2'd2); cpuRead(2'd3);
        cpuWrite(2'd2, 8'h18);
        scrXfer(1, 1'b0, 1'b0);
        cpuRead(2'd2);

        $display("[TB] round robin");
        cpuWrite(2'd0, 8'h00);
        cpuWrite(2'd2, 8'h00);
        b = 8'($urandom);
        cpuWrite(2'd3, b);
        scr_q.push_back(b);
        bus.scr_ready = 1'b1;
        bus.kb_valid  = 1'b1;
        bus.kb_data   = 8'($urandom);
        rr_active = 1'b1;
        cpuWrite(2'd0, 8'h10);
        cpuWrite(2'd2, 8'h10);
        cyc = 0;
        while (cyc < 80 && grants.size() < 6) begin
            @(negedge clk);
            hs = bus.scr_valid && bus.scr_ready;
            @(posedge clk); #1;
            cyc++;
            bus.kb_data = 8'($urandom);
            if (hs && grants.size() < 5) begin
                b = 8'($urandom);
                cpuWrite(2'd3, b);
                scr_q.push_back(b);
            end
        end
        rr_active = 1'b0;
        bus.kb_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.scr_ready = 1'b0;
        m_scr_dba = 1;
        checkCount("grant_count", grants.size(), 6);
        for (int i = 0; i < grants.size(); i++)
            checkOutput("grant_order", grants[i], (i % 2 == 1) ? 8'h53 : 8'h4B);

        $display("[TB] reset during transfer");
        cpuWrite(2'd3, 8'($urandom));
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("scr_valid_before_reset", {7'b0, bus.scr_valid}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_scr_valid", {7'b0, bus.scr_valid}, 8'h00);
        checkOutput("async_reset_kb_ready", {7'b0, bus.kb_ready}, 8'h00);
        checkOutput("async_reset_scr_data", bus.scr_data, 8'h00);
        checkOutput("async_reset_irq", {7'b0, bus.irq}, 8'h00);
        modelReset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpuRead(2'd0); cpuRead(2'd2); cpuRead(2'd3);
        checkIrq();

        $display("[TB] stalled screen");
        b = 8'($urandom);
        cpuWrite(2'd2, 8'h10);
        cpuWrite(2'd3, b);
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (bus.scr_valid) break;
        end
        checkCount("scr_grant_latency", n, 2);
`ifdef IO_DEV_ARB_TIMEOUT_EN
        n = 1;
        while (n < 400) begin
            @(negedge clk);
            if (!bus.scr_valid) break;
            n++;
        end
        checkCount("timeout_cycles", n, 255);
        @(posedge clk); #1;
        m_scr_of  = 1;
        m_scr_dba = 1;
        cpuRead(2'd2);
`else
        repeat (300) @(negedge clk);
        checkOutput("no_timeout_scr_valid", {7'b0, bus.scr_valid}, 8'h01);
        checkOutput("no_timeout_scr_data", bus.scr_data, b);
        @(posedge clk); #1;
        scr_q.push_back(b);
        bus.scr_ready = 1'b1;
        @(posedge clk); #1;
        bus.scr_ready = 1'b0;
        m_scr_dba = 1;
        cpuRead(2'd2);
`endif
        repeat (2) @(posedge clk);
        #1;
        checkCount("rd_queue_drained", rd_q.size(), 0);
        checkCount("scr_queue_drained", scr_q.size(), 0);
        printSummary();
        $finish;
    end
endmodule
